// File: rtl/fir_mc_filter.sv
`default_nettype none
// ============================================================================
// Module      : fir_mc_filter
// Description : Time-multiplexed multi-channel FIR filter. A single shared
//               multiply-accumulate unit serves N_CH independent channels,
//               each with its own sample delay line. All channels share one
//               run-time writable coefficient RAM (Q1.OUT_SHIFT format).
//               The result is rounded half toward +inf and saturated.
//
// Ports       :
//   ck          in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_data     in   input sample (signed, DATA_W)
//   in_ch       in   channel of in_data
//   in_valid    in   input sample valid
//   in_ready    out  block can accept a sample (IDLE only)
//   coef_we     in   coefficient write strobe (honoured in IDLE only)
//   coef_addr   in   tap index to write
//   coef_data   in   coefficient value (signed, COEF_W)
//   coef_ready  out  coefficient writes honoured (IDLE only)
//   out_data    out  filtered sample, registered
//   out_ch      out  channel of out_data
//   out_valid   out  out_data/out_ch/out_sat valid
//   out_ready   in   downstream accepts the output
//   out_sat     out  out_data was clipped
//
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mc_filter #(
  parameter  int DATA_W    = 24,
  parameter  int COEF_W    = 16,
  parameter  int N_TAPS    = 16,
  parameter  int N_CH      = 2,
  parameter  int OUT_SHIFT = 14,
  localparam int ADDR_W    = $clog2(N_TAPS),
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int PROD_W = DATA_W + COEF_W;
  // ADDR_W guard bits: the sum of N_TAPS full-scale products cannot wrap.
  localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

  // 1.0 in Q1.OUT_SHIFT, the identity coefficient for tap 0.
  localparam logic [COEF_W-1:0] COEF_ONE =
    {{(COEF_W-OUT_SHIFT-1){1'b0}}, 1'b1, {OUT_SHIFT{1'b0}}};

  // Half an LSB of the output, added before the arithmetic shift.
  localparam logic [ACC_W:0] RND =
    {{(ACC_W-OUT_SHIFT+1){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};

  // Output range limits, sign-extended to the rounding width.
  localparam logic signed [ACC_W:0] R_MAX =
    {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] R_MIN =
    {{(ACC_W+1-DATA_W){1'b1}}, 1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MAC    = 3'd2,
    S_ROUND  = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t state_q, state_d;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] x_q    [0:N_CH-1][0:N_TAPS-1];
  logic [DATA_W-1:0] x_d    [0:N_CH-1][0:N_TAPS-1];
  logic [COEF_W-1:0] coef_q [0:N_TAPS-1];
  logic [COEF_W-1:0] coef_d [0:N_TAPS-1];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]       tap_q, tap_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [DATA_W-1:0]       sample_q, sample_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic                    out_sat_q, out_sat_d;

  // --------------------------------------------------------------------------
  // Channel range check. When N_CH fills the in_ch encoding every value is
  // legal, so the compare is dropped rather than left constant.
  // --------------------------------------------------------------------------
  logic ch_ok;

  generate
    if ((1 << CH_W) == N_CH) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = (in_ch < CH_W'(N_CH));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Datapath: one product per cycle, and the rounding/saturation stage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]       x_sel;
  logic [COEF_W-1:0]       c_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W:0]    rsum;
  logic signed [ACC_W:0]    rshift;

  always_comb begin
    x_sel    = x_q[ch_q][tap_q];
    c_sel    = coef_q[tap_q];
    // Both operands are sign-extended to the full product width, so the
    // truncated product equals the exact signed product.
    prod     = $signed({{COEF_W{x_sel[DATA_W-1]}}, x_sel}) *
               $signed({{DATA_W{c_sel[COEF_W-1]}}, c_sel});
    prod_ext = {{ADDR_W{prod[PROD_W-1]}}, prod};
    // One extra bit keeps the rounding addition from overflowing.
    rsum     = {acc_q[ACC_W-1], acc_q} + RND;
    rshift   = rsum >>> OUT_SHIFT;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    coef_d     = coef_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    ch_d       = ch_q;
    sample_d   = sample_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        tap_d = '0;
        // Out-of-range channels are accepted and silently dropped.
        if (in_valid && ch_ok) begin
          ch_d     = in_ch;
          sample_d = in_data;
          state_d  = S_LOAD;
        end
        // A write landing on the same edge as the input handshake is
        // already in the RAM when the MAC reads it.
        if (coef_we) begin
          for (int t = 0; t < N_TAPS; t++) begin
            if (ADDR_W'(t) == coef_addr) begin
              coef_d[t] = coef_data;
            end
          end
        end
      end

      S_LOAD: begin
        for (int c = 0; c < N_CH; c++) begin
          if (CH_W'(c) == ch_q) begin
            for (int k = N_TAPS - 1; k > 0; k--) begin
              x_d[c][k] = x_q[c][k-1];
            end
            x_d[c][0] = sample_q;
          end
        end
        state_d = S_MAC;
      end

      S_MAC: begin
        acc_d = acc_q + prod_ext;
        tap_d = tap_q + ADDR_W'(1);
        if (tap_q == LAST_TAP) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        out_ch_d = ch_q;
        if (rshift > R_MAX) begin
          out_data_d = SAT_POS;
          out_sat_d  = 1'b1;
        end else if (rshift < R_MIN) begin
          out_data_d = SAT_NEG;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = rshift[DATA_W-1:0];
          out_sat_d  = 1'b0;
        end
        state_d = S_OUTPUT;
      end

      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      tap_q      <= '0;
      ch_q       <= '0;
      sample_q   <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_sat_q  <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < N_TAPS; k++) begin
          x_q[c][k] <= '0;
        end
      end
      for (int t = 0; t < N_TAPS; t++) begin
        coef_q[t] <= (t == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      ch_q       <= ch_d;
      sample_q   <= sample_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_sat_q  <= out_sat_d;
      x_q        <= x_d;
      coef_q     <= coef_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: handshake flags decode the registered state only.
  // --------------------------------------------------------------------------
  assign in_ready   = (state_q == S_IDLE);
  assign coef_ready = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUTPUT);
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_sat    = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mc_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mc_filter
// Description : Directed self-checking bench for fir_mc_filter (defaults:
//               24-bit data, 16-bit Q1.14 coefficients, 16 taps, 2 channels).
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mc_filter;

  localparam int  DATA_W = 24;
  localparam int  COEF_W = 16;
  localparam int  N_TAPS = 16;
  localparam longint P_MAX = 8388607;
  localparam longint P_MIN = -8388608;

  logic              ck = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic [0:0]        in_ch = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              coef_ready;
  logic [DATA_W-1:0] out_data;
  logic [0:0]        out_ch;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_sat;

  int checks   = 0;
  int failures = 0;

  fir_mc_filter dut (
    .ck         (ck),
    .rst        (rst),
    .in_data    (in_data),
    .in_ch      (in_ch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sat    (out_sat)
  );

  always #5 ck = ~ck;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
  endtask

  task automatic wr_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = COEF_W'(val);
    @(negedge ck);
    coef_we = 1'b0;
  endtask

  task automatic send(input int ch, input longint val);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge ck);
      n++;
    end
    chk("send_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_ch    = 1'(ch);
    in_data  = DATA_W'(val);
    @(negedge ck);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks the result and lets the handshake complete.
  task automatic recv(input string tag, input longint exp_d, input int exp_ch,
                      input int exp_sat, input bit chk_lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge ck);
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (chk_lat) chk({tag, "_latency"}, 64'(n), 64'(N_TAPS + 2));
    chk({tag, "_data"}, 64'($signed(out_data)), 64'(exp_d));
    chk({tag, "_ch"},   64'(out_ch),  64'(exp_ch));
    chk({tag, "_sat"},  64'(out_sat), 64'(exp_sat));
    @(negedge ck);
  endtask

  function automatic longint clip(input longint s);
    if (s > P_MAX) return P_MAX;
    if (s < P_MIN) return P_MIN;
    return s;
  endfunction

  int     t2_in  [5] = '{4000, 0, 0, 0, 0};
  int     t2_exp [5] = '{1000, 1000, 1000, 1000, 0};
  longint s;

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_coef_ready", 64'(coef_ready), 64'd1);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_out_ch",     64'(out_ch),     64'd0);
    chk("rst_out_sat",    64'(out_sat),    64'd0);
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);

    // 1: identity coefficients pass the sample through, with fixed latency
    send(0, 1000);
    recv("t1", 1000, 0, 0, 1'b1);
    chk("t1_idle_after", 64'(out_valid), 64'd0);

    // 2: four taps of 0.25, impulse response
    do_reset();
    for (int i = 0; i < 4; i++) wr_coef(i, 4096);
    for (int i = 0; i < 5; i++) begin
      send(0, t2_in[i]);
      recv("t2", t2_exp[i], 0, 0, 1'b0);
    end

    // 3: channels interleaved; ch1 never sees ch0's impulse
    do_reset();
    for (int i = 0; i < 4; i++) wr_coef(i, 4096);
    for (int i = 0; i < 5; i++) begin
      send(0, t2_in[i]);
      recv("t3_ch0", t2_exp[i], 0, 0, 1'b0);
      send(1, 0);
      recv("t3_ch1", 0, 1, 0, 1'b0);
    end

    // 4: all coefficients 1.0, full-scale positive then negative (saturation)
    do_reset();
    for (int i = 1; i < N_TAPS; i++) wr_coef(i, 16384);
    for (int k = 1; k <= N_TAPS; k++) begin
      send(0, P_MAX);
      s = longint'(k) * P_MAX;
      recv("t4_pos", clip(s), 0, (s > P_MAX) ? 1 : 0, 1'b0);
    end
    for (int j = 1; j <= N_TAPS; j++) begin
      send(0, P_MIN);
      s = longint'(N_TAPS - j) * P_MAX + longint'(j) * P_MIN;
      recv("t4_neg", clip(s), 0, (s > P_MAX || s < P_MIN) ? 1 : 0, 1'b0);
    end

    // 5: back-pressure holds the output; coefficient writes are ignored
    do_reset();
    out_ready = 1'b0;
    send(0, 777);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge ck);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      coef_we   = 1'b1;
      coef_addr = 4'd0;
      coef_data = '0;
      chk("t5_hold_valid",  64'(out_valid), 64'd1);
      chk("t5_hold_data",   64'($signed(out_data)), 64'd777);
      chk("t5_in_ready",    64'(in_ready),   64'd0);
      chk("t5_coef_ready",  64'(coef_ready), 64'd0);
      @(negedge ck);
    end
    coef_we   = 1'b0;
    out_ready = 1'b1;
    @(negedge ck);
    chk("t5_release_valid", 64'(out_valid), 64'd0);
    chk("t5_release_ready", 64'(in_ready),  64'd1);
    // Coefficient 0 must still be 1.0 and x[1]=777 sees coefficient 0.0.
    send(0, 300);
    recv("t5_after", 300, 0, 0, 1'b0);

    // 6: reset during MAC aborts the sample
    send(0, 1234);
    repeat (5) @(negedge ck);
    rst = 1'b1;
    #1;
    chk("t6_out_valid",  64'(out_valid),  64'd0);
    chk("t6_in_ready",   64'(in_ready),   64'd1);
    chk("t6_coef_ready", 64'(coef_ready), 64'd1);
    chk("t6_out_data",   64'(out_data),   64'd0);
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    send(0, 500);
    recv("t6_after", 500, 0, 0, 1'b1);

    // 7: write coincident with input handshake applies; half-up rounding
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 16'd8192;
    in_valid  = 1'b1;
    in_ch     = 1'b0;
    in_data   = DATA_W'(600);
    @(negedge ck);
    coef_we  = 1'b0;
    in_valid = 1'b0;
    recv("t7_coincident", 300, 0, 0, 1'b0);
    send(1, 3);
    recv("t7_round_pos", 2, 1, 0, 1'b0);
    send(1, -3);
    recv("t7_round_neg", -1, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
